// File: rtl/run_pattern_gen.sv
// Serial run-length pattern transmitter: emits ones_len 1-bits then zeros_len 0-bits,
// repeated rep_cnt times, with a reference consecutive-ones detect flag per bit.
module run_pattern_gen #(
    parameter int CNT_W      = 4,
    parameter int DETECT_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] ones_len,
    input  logic [CNT_W-1:0] zeros_len,
    input  logic [CNT_W-1:0] rep_cnt,
    output logic             out,
    output logic             out_valid,
    output logic             expect_det,
    output logic             busy,
    output logic             done
);

    localparam int RUN_W = (DETECT_LEN < 2) ? 1 : $clog2(DETECT_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONES  = 2'd1,
        ZEROS = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic [CNT_W-1:0]   zeros_q, zeros_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               expect_q, expect_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               end_rep;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rep_q       <= '0;
            ones_q      <= '0;
            zeros_q     <= '0;
            run_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            expect_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            ones_q      <= ones_d;
            zeros_q     <= zeros_d;
            run_q       <= run_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            expect_q    <= expect_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // cnt_q holds the bits left in the current phase, including the one being emitted now.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        ones_d  = ones_q;
        zeros_d = zeros_q;
        done_d  = 1'b0;
        end_rep = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    ones_d  = ones_len;
                    zeros_d = zeros_len;
                    rep_d   = (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;
                    if (ones_len != '0) begin
                        state_d = ONES;
                        cnt_d   = ones_len;
                    end else if (zeros_len != '0) begin
                        state_d = ZEROS;
                        cnt_d   = zeros_len;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ONES: begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (zeros_q != '0) begin
                    state_d = ZEROS;
                    cnt_d   = zeros_q;
                end else begin
                    end_rep = 1'b1;
                end
            end
            ZEROS: begin
                if (cnt_q > CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    end_rep = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (end_rep) begin
            if (rep_q > CNT_W'(1)) begin
                rep_d = rep_q - CNT_W'(1);
                if (ones_q != '0) begin
                    state_d = ONES;
                    cnt_d   = ones_q;
                end else begin
                    state_d = ZEROS;
                    cnt_d   = zeros_q;
                end
            end else begin
                rep_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        // Outputs are registered from the state about to be entered.
        out_d       = (state_d == ONES);
        out_valid_d = (state_d != IDLE);
        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d == IDLE);
        if (state_d == ONES) begin
            run_d = (run_q < RUN_W'(DETECT_LEN)) ? run_q + RUN_W'(1) : run_q;
        end else begin
            run_d = '0;
        end
        expect_d = (state_d == ONES) && (run_d >= RUN_W'(DETECT_LEN));
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign expect_det = expect_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cmd_ready  = cmd_ready_q;

endmodule

// File: tb/tb_run_pattern_gen.sv
// Bench for run_pattern_gen: per-cycle queue model of the expected bit stream,
// directed literal scenarios and randomized commands with occasional resets.
module tb_run_pattern_gen;

    localparam int CNT_W      = 4;
    localparam int DETECT_LEN = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [CNT_W-1:0] ones_len = '0;
    logic [CNT_W-1:0] zeros_len = '0;
    logic [CNT_W-1:0] rep_cnt = '0;
    logic             dout, out_valid, exp_det, busy, done;

    int checks = 0;
    int failures = 0;

    run_pattern_gen #(.CNT_W(CNT_W), .DETECT_LEN(DETECT_LEN)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .ones_len(ones_len), .zeros_len(zeros_len), .rep_cnt(rep_cnt),
        .out(dout), .out_valid(out_valid), .expect_det(exp_det),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, want);
        end
    endtask

    // Expected stream: one entry per cycle following an accept; empty queue means idle.
    typedef struct {
        bit v;
        bit o;
        bit e;
        bit b;
        bit d;
    } cyc_t;

    cyc_t expq[$];
    bit   rdy_m = 1'b0;

    task automatic build(input int o, input int z, input int r);
        int reps;
        int run;
        cyc_t c;
        reps = (r == 0) ? 1 : r;
        run  = 0;
        for (int k = 0; k < reps; k++) begin
            for (int i = 0; i < o; i++) begin
                run++;
                c = '{v: 1, o: 1, e: (run >= DETECT_LEN), b: 1, d: 0};
                expq.push_back(c);
            end
            for (int i = 0; i < z; i++) begin
                run = 0;
                c = '{v: 1, o: 0, e: 0, b: 1, d: 0};
                expq.push_back(c);
            end
        end
        c = '{v: 0, o: 0, e: 0, b: 0, d: 1};
        expq.push_back(c);
    endtask

    always @(negedge clk) begin
        cyc_t e;
        bit ready_e;
        if (reset) begin
            chk("rst_out", dout, 1'b0);
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_expect", exp_det, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_ready", cmd_ready, 1'b0);
            expq.delete();
            rdy_m = 1'b0;
        end else begin
            if (expq.size() > 0) e = expq.pop_front();
            else e = '{v: 0, o: 0, e: 0, b: 0, d: 0};
            ready_e = rdy_m && !e.b;
            rdy_m = 1'b1;
            chk("m_out", dout, e.o);
            chk("m_valid", out_valid, e.v);
            chk("m_expect", exp_det, e.e);
            chk("m_busy", busy, e.b);
            chk("m_done", done, e.d);
            chk("m_ready", cmd_ready, ready_e);
            if (cmd_valid && ready_e) build(int'(ones_len), int'(zeros_len), int'(rep_cnt));
        end
    end

    logic cap_out [1:40];
    logic cap_val [1:40];
    logic cap_exp [1:40];
    logic cap_done[1:40];
    logic cap_busy[1:40];
    logic cap_rdy [1:40];

    task automatic capture(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            cap_out[i]  = dout;
            cap_val[i]  = out_valid;
            cap_exp[i]  = exp_det;
            cap_done[i] = done;
            cap_busy[i] = busy;
            cap_rdy[i]  = cmd_ready;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge (start of cycle 1).
    task automatic send(input logic [3:0] o, input logic [3:0] z, input logic [3:0] r,
                        input bit hold);
        bit acc;
        acc = 1'b0;
        ones_len  = o;
        zeros_len = z;
        rep_cnt   = r;
        cmd_valid = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            if (cmd_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout t=%0t got=no_accept want=accept", $time);
        end
        if (!hold) begin
            cmd_valid = 1'b0;
            ones_len  = 4'($urandom);
            zeros_len = 4'($urandom);
            rep_cnt   = 4'($urandom);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ones_len  = 4'($urandom);
            zeros_len = 4'($urandom);
            rep_cnt   = 4'($urandom);
        end
    endtask

    initial begin
        logic [5:0] w_out;
        logic [5:0] w_exp;
        logic [5:0] w_pat;
        int o, z, r;

        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(2);

        // ones=3 zeros=2 rep=1
        send(4'd3, 4'd2, 4'd1, 1'b0);
        capture(6);
        w_out = 6'b000111;
        w_exp = 6'b000100;
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("t1_out[%0d]", i), cap_out[i], w_out[i-1]);
            chk($sformatf("t1_exp[%0d]", i), cap_exp[i], w_exp[i-1]);
        end
        chk("t1_done6", cap_done[6], 1'b1);
        chk("t1_rdy6", cap_rdy[6], 1'b1);
        chk("t1_done5", cap_done[5], 1'b0);
        @(posedge clk); #1;

        // ones=2 zeros=0 rep=3: runs continue across repetitions
        send(4'd2, 4'd0, 4'd3, 1'b0);
        capture(7);
        w_exp = 6'b111100;
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("t2_out[%0d]", i), cap_out[i], 1'b1);
            chk($sformatf("t2_exp[%0d]", i), cap_exp[i], w_exp[i-1]);
        end
        chk("t2_done7", cap_done[7], 1'b1);
        chk("t2_val7", cap_val[7], 1'b0);
        @(posedge clk); #1;

        // empty command
        send(4'd0, 4'd0, 4'd5, 1'b0);
        capture(2);
        chk("t3_done1", cap_done[1], 1'b1);
        chk("t3_busy1", cap_busy[1], 1'b0);
        chk("t3_val1", cap_val[1], 1'b0);
        chk("t3_done2", cap_done[2], 1'b0);
        @(posedge clk); #1;

        // maximum lengths, rep=0 -> 1; next command queued with valid held
        send(4'd15, 4'd15, 4'd0, 1'b0);
        ones_len  = 4'd3;
        zeros_len = 4'd1;
        rep_cnt   = 4'd1;
        cmd_valid = 1'b1;
        capture(34);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("t4_exp2", cap_exp[2], 1'b0);
        chk("t4_exp3", cap_exp[3], 1'b1);
        chk("t4_exp15", cap_exp[15], 1'b1);
        chk("t4_out16", cap_out[16], 1'b0);
        chk("t4_val30", cap_val[30], 1'b1);
        chk("t4_done30", cap_done[30], 1'b0);
        chk("t4_done31", cap_done[31], 1'b1);
        chk("t4_rdy31", cap_rdy[31], 1'b1);
        chk("t4_out32", cap_out[32], 1'b1);
        chk("t4_exp32", cap_exp[32], 1'b0);
        chk("t4_exp34", cap_exp[34], 1'b1);
        idle_cycles(4);

        // reset in cycle 3 of a command
        send(4'd5, 4'd1, 4'd2, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t5_out_rst", dout, 1'b0);
        chk("t5_val_rst", out_valid, 1'b0);
        chk("t5_busy_rst", busy, 1'b0);
        chk("t5_rdy_rst", cmd_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_rdy_rel", cmd_ready, 1'b0);
        chk("t5_done_rel", done, 1'b0);
        @(posedge clk); #1;
        send(4'd1, 4'd1, 4'd1, 1'b0);
        capture(3);
        chk("t5_out1", cap_out[1], 1'b1);
        chk("t5_out2", cap_out[2], 1'b0);
        chk("t5_exp1", cap_exp[1], 1'b0);
        chk("t5_exp2", cap_exp[2], 1'b0);
        chk("t5_done3", cap_done[3], 1'b1);
        @(posedge clk); #1;

        // valid held with fields changing while busy
        send(4'd2, 4'd1, 4'd2, 1'b1);
        w_pat = 6'b011011;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk($sformatf("t6_out[%0d]", i), dout, w_pat[i-1]);
            @(posedge clk); #1;
            ones_len  = 4'($urandom_range(0, 4));
            zeros_len = 4'($urandom_range(0, 3));
            rep_cnt   = 4'($urandom_range(0, 2));
        end
        idle_cycles(3);
        cmd_valid = 1'b0;
        idle_cycles(40);

        // randomized commands
        for (int n = 0; n < 40; n++) begin
            o = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 6);
            z = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4);
            r = $urandom_range(0, 3);
            send(4'(o), 4'(z), 4'(r), 1'b0);
            if ($urandom_range(0, 11) == 0) begin
                idle_cycles($urandom_range(0, 4));
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
            end
            idle_cycles($urandom_range(0, 3));
        end

        idle_cycles(200);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
